pwe_multi: RTL and testbench

- Parametrised successor to the single-shot pulse-width engine: generates a programmable burst of pulses with programmable high time, low gap and pulse count, plus a continuous mode.
- Adds abort, graceful stop, a completed-pulse counter and registered outputs.
- Sits behind the top-level pin wrapper.
- Programmed values are latched on start, so pin changes mid-burst have no effect.

---
 rtl/pwe_multi.sv | 111 +++++++++++
 tb/tb_pwe_multi.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwe_multi.sv
// Multi-pulse width engine: programmable burst or continuous pulse train with
// abort, graceful stop, completed-pulse counter and fully registered outputs.
module pwe_multi #(
  parameter int   WIDTH      = 8,
  parameter int   COUNT_W    = 4,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               start,
  input  logic               abort,
  input  logic               mode,
  input  logic [WIDTH-1:0]   high_len,
  input  logic [WIDTH-1:0]   gap_len,
  input  logic [COUNT_W-1:0] n_pulses,
  output logic               pulse_out,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [COUNT_W-1:0] pulse_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [WIDTH-1:0]   W_ONE = WIDTH'(1);
  localparam logic [COUNT_W-1:0] C_ONE = COUNT_W'(1);

  logic [1:0]         state;
  logic [WIDTH-1:0]   cnt;
  logic [WIDTH-1:0]   hi_l;
  logic [WIDTH-1:0]   gap_l;
  logic [COUNT_W-1:0] np_l;
  logic               mode_l;
  logic               last_pulse;

  // np_l is normalised to >=1 at latch time and pulse_cnt starts at 0, so the
  // burst end is reached before pulse_cnt can wrap.
  assign last_pulse = mode_l ? ~enable : ((pulse_cnt + C_ONE) == np_l);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      hi_l      <= '0;
      gap_l     <= '0;
      np_l      <= '0;
      mode_l    <= 1'b0;
      pulse_out <= IDLE_LEVEL;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      pulse_cnt <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && enable && !abort) begin
            hi_l      <= high_len;
            gap_l     <= (gap_len == '0) ? W_ONE : gap_len;
            np_l      <= (n_pulses == '0) ? C_ONE : n_pulses;
            mode_l    <= mode;
            pulse_cnt <= '0;
            if (high_len == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state     <= S_HIGH;
              cnt       <= high_len - W_ONE;
              pulse_out <= ~IDLE_LEVEL;
              busy      <= 1'b1;
            end
          end
        end
        S_HIGH, S_GAP: begin
          if (abort) begin
            // a truncated high phase is deliberately not counted
            state     <= S_IDLE;
            pulse_out <= IDLE_LEVEL;
            busy      <= 1'b0;
            aborted   <= 1'b1;
          end else if (cnt != '0) begin
            cnt <= cnt - W_ONE;
          end else if (state == S_HIGH) begin
            pulse_cnt <= pulse_cnt + C_ONE;
            pulse_out <= IDLE_LEVEL;
            if (last_pulse) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= S_GAP;
              cnt   <= gap_l - W_ONE;
            end
          end else begin
            state     <= S_HIGH;
            cnt       <= hi_l - W_ONE;
            pulse_out <= ~IDLE_LEVEL;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwe_multi.sv
// Self-checking bench for pwe_multi: phase-arithmetic reference model compared
// every cycle, plus hand-computed waveform checks and an inverted-level instance.
module tb_pwe_multi;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable, start, abort, mode;
  logic [7:0] high_len, gap_len;
  logic [3:0] n_pulses;
  logic       pulse_out, busy, done, aborted;
  logic [3:0] pulse_cnt;

  logic       b_enable, b_start, b_abort, b_mode;
  logic [3:0] b_high_len, b_gap_len, b_n;
  logic       b_po, b_busy, b_done, b_aborted;
  logic [3:0] b_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pwe_multi u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .abort(abort),
    .mode(mode), .high_len(high_len), .gap_len(gap_len), .n_pulses(n_pulses),
    .pulse_out(pulse_out), .busy(busy), .done(done), .aborted(aborted),
    .pulse_cnt(pulse_cnt)
  );

  pwe_multi #(.WIDTH(4), .COUNT_W(4), .IDLE_LEVEL(1'b1)) u_inv (
    .clk(clk), .rst_n(rst_n), .enable(b_enable), .start(b_start), .abort(b_abort),
    .mode(b_mode), .high_len(b_high_len), .gap_len(b_gap_len), .n_pulses(b_n),
    .pulse_out(b_po), .busy(b_busy), .done(b_done), .aborted(b_aborted),
    .pulse_cnt(b_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: a run is a cycle index k since the start edge; the pulse
  // train is periodic with period h+g, high while (k mod period) < h.
  int         m_h = 0, m_g = 1, m_n = 1, m_k = 0;
  bit         m_mode = 0, m_run = 0, m_dn = 0, m_ab = 0;
  logic [3:0] m_cnt = '0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_run = 0; m_dn = 0; m_ab = 0; m_cnt = '0; m_k = 0;
    end
    chk("model_pulse_out", pulse_out,
        (m_run && ((m_k % (m_h + m_g)) < m_h)) ? 1 : 0);
    chk("model_busy", busy, m_run);
    chk("model_done", done, m_dn);
    chk("model_aborted", aborted, m_ab);
    chk("model_pulse_cnt", pulse_cnt, m_cnt);
    if (rst_n) begin
      bit prev_dn;
      prev_dn = m_dn;
      m_dn = 0;
      m_ab = 0;
      if (m_run) begin
        if (abort) begin
          m_run = 0;
          m_ab  = 1;
        end else begin
          if ((m_k % (m_h + m_g)) == m_h - 1) begin
            m_cnt = m_cnt + 4'd1;
            if ((!m_mode && (m_k / (m_h + m_g) + 1) == m_n) || (m_mode && !enable)) begin
              m_run = 0;
              m_dn  = 1;
            end
          end
          m_k++;
        end
      end else if (!prev_dn && start && enable && !abort) begin
        m_h    = int'(high_len);
        m_g    = (gap_len == 0) ? 1 : int'(gap_len);
        m_n    = (n_pulses == 0) ? 1 : int'(n_pulses);
        m_mode = mode;
        m_cnt  = '0;
        m_k    = 0;
        if (m_h == 0) m_dn = 1;
        else          m_run = 1;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Issue a start; returns one step into cycle T+1 with start already released.
  task automatic go(input int h, input int g, input int n, input bit md);
    high_len = 8'(h); gap_len = 8'(g); n_pulses = 4'(n); mode = md; start = 1'b1;
    nxt();
    start = 1'b0;
  endtask

  initial begin
    logic [14:0] bp;
    logic [6:0]  gp;
    int lows;
    enable = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
    high_len = '0; gap_len = '0; n_pulses = '0;
    b_enable = 1'b1; b_start = 1'b0; b_abort = 1'b0; b_mode = 1'b0;
    b_high_len = '0; b_gap_len = 4'd1; b_n = 4'd1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_pulse_out", pulse_out, 0);
    chk("reset_pulse_cnt", pulse_cnt, 0);
    chk("reset_inv_level", b_po, 1);
    nxt();

    // burst 3/2/3
    bp = 15'b011100111001110;
    go(3, 2, 3, 0);
    for (int i = 1; i <= 14; i++) begin
      chk("burst_pulse_out", pulse_out, bp[i]);
      chk("burst_done", done, (i == 14) ? 1 : 0);
      if (i == 14) begin
        chk("burst_busy_end", busy, 0);
        chk("burst_pulse_cnt", pulse_cnt, 3);
      end else nxt();
    end
    nxt(); nxt();

    // zero high_len
    go(0, 5, 2, 0);
    chk("h0_done", done, 1);
    chk("h0_pulse_out", pulse_out, 0);
    nxt(); nxt();

    // n_pulses=0 treated as 1
    go(1, 3, 0, 0);
    chk("n0_pulse_out", pulse_out, 1);
    nxt();
    chk("n0_done", done, 1);
    chk("n0_pulse_cnt", pulse_cnt, 1);
    nxt(); nxt();

    // gap_len=0 treated as 1
    gp = 7'b0110110;
    go(2, 0, 2, 0);
    for (int i = 1; i <= 6; i++) begin
      chk("gap0_pulse_out", pulse_out, gp[i]);
      if (i == 6) chk("gap0_done", done, 1);
      else nxt();
    end
    nxt(); nxt();

    // continuous, counter wrap, graceful stop from GAP
    go(2, 1, 0, 1);
    for (int i = 1; i < 48; i++) nxt();
    chk("cont_gap_level", pulse_out, 0);
    chk("cont_wrap_cnt", pulse_cnt, 0);
    enable = 1'b0;
    nxt(); nxt();
    chk("cont_last_pulse", pulse_out, 1);
    nxt();
    chk("cont_stop_done", done, 1);
    chk("cont_stop_cnt", pulse_cnt, 1);
    enable = 1'b1;
    nxt(); nxt();

    // abort in 2nd cycle of pulse 2
    go(4, 2, 3, 0);
    for (int i = 1; i < 8; i++) nxt();
    chk("abort_pre_high", pulse_out, 1);
    abort = 1'b1;
    nxt();
    abort = 1'b0;
    chk("abort_pulse_out", pulse_out, 0);
    chk("abort_strobe", aborted, 1);
    chk("abort_no_done", done, 0);
    chk("abort_pulse_cnt", pulse_cnt, 1);
    nxt();
    chk("abort_strobe_clr", aborted, 0);

    // abort + start in IDLE
    high_len = 8'd3; start = 1'b1; abort = 1'b1;
    nxt(); nxt();
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_strobe", aborted, 0);
    start = 1'b0; abort = 1'b0;
    nxt();

    // pins change mid-burst
    go(3, 2, 2, 0);
    high_len = 8'd7; gap_len = 8'd9; n_pulses = 4'd9; mode = 1'b1;
    for (int i = 1; i < 9; i++) nxt();
    chk("latched_done", done, 1);
    nxt(); nxt();

    // reset mid-HIGH
    go(10, 1, 1, 0);
    nxt(); nxt(); nxt();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pulse_out", pulse_out, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_cnt", pulse_cnt, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    nxt(); nxt(); nxt();
    chk("post_rst_idle", busy, 0);

    // inverted idle level, 15-cycle pulse, length change mid-pulse
    b_high_len = 4'd15; b_start = 1'b1;
    nxt();
    b_start = 1'b0;
    lows = 0;
    for (int i = 1; i <= 17; i++) begin
      if (i == 5) b_high_len = 4'd3;
      if (b_po == 1'b0) lows++;
      if (i == 16) begin
        chk("inv_after_pulse", b_po, 1);
        chk("inv_done", b_done, 1);
      end
      nxt();
    end
    chk("inv_low_cycles", lows, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
